// File: rtl/cons_run_ctl.sv
// Console run-control sequencer. Turns discrete console commands into the
// consRUN/consCONT/consEXEC/consSTEP levels seen by the CPU. Each command
// completes on the CPU's cpuCONT/cpuHALT handshake, with a bounded wait in
// every wait state. Halt/unhalt edges are reported separately as pulses.
module cons_run_ctl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNTW    = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       consRUN,
  output logic       consCONT,
  output logic       consEXEC,
  output logic       consSTEP,
  input  logic       cpuHALT,
  input  logic       cpuRUN,
  input  logic       cpuCONT,
  output logic       busy,
  output logic       timeout,
  output logic       halt_evt,
  output logic       unhalt_evt
);

  localparam logic [2:0] CmdNop    = 3'd0;
  localparam logic [2:0] CmdRun    = 3'd1;
  localparam logic [2:0] CmdHalt   = 3'd2;
  localparam logic [2:0] CmdCont   = 3'd3;
  localparam logic [2:0] CmdExec   = 3'd4;
  localparam logic [2:0] CmdStep   = 3'd5;
  localparam logic [2:0] CmdClrErr = 3'd6;

  // Last count value of a wait before it is abandoned.
  localparam logic [CNTW-1:0] CntMax = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitAck  = 2'd1,
    StWaitDrop = 2'd2,
    StWaitHalt = 2'd3
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic            r_run, w_run_nxt;
  logic            r_cont, w_cont_nxt;
  logic            r_exec, w_exec_nxt;
  logic            r_step, w_step_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            r_halt_last;
  logic            r_halt_evt;
  logic            r_unhalt_evt;
  logic            w_exit;
  logic            w_cnt_max;

  // cpuRUN is status only; the sequencer never waits on it.
  logic w_unused;
  assign w_unused = cpuRUN;

  // Exit condition of the current wait state.
  always_comb begin
    w_exit = 1'b0;
    unique case (r_state)
      StWaitAck:  w_exit = cpuCONT;
      StWaitDrop: w_exit = ~cpuCONT;
      StWaitHalt: w_exit = cpuHALT;
      default:    w_exit = 1'b0;
    endcase
  end

  assign w_cnt_max = (r_cnt == CntMax);

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_run_nxt     = r_run;
    w_cont_nxt    = r_cont;
    w_exec_nxt    = r_exec;
    w_step_nxt    = r_step;
    w_timeout_nxt = r_timeout;

    if (r_state == StIdle) begin
      w_cnt_nxt = '0;
      if (cmd_valid) begin
        unique case (cmd_code)
          CmdRun: w_run_nxt = 1'b1;
          CmdHalt: begin
            w_run_nxt   = 1'b0;
            w_state_nxt = StWaitHalt;
          end
          CmdCont: begin
            w_cont_nxt  = 1'b1;
            w_state_nxt = StWaitAck;
          end
          CmdExec: begin
            w_cont_nxt  = 1'b1;
            w_exec_nxt  = 1'b1;
            w_state_nxt = StWaitAck;
          end
          CmdStep: begin
            w_cont_nxt  = 1'b1;
            w_step_nxt  = 1'b1;
            w_state_nxt = StWaitAck;
          end
          CmdClrErr: w_timeout_nxt = 1'b0;
          default: ;  // CmdNop and reserved code: accepted, no effect
        endcase
      end
    end else if (w_exit) begin
      // Exit beats a coincident timeout.
      w_cnt_nxt = '0;
      unique case (r_state)
        StWaitAck: begin
          w_cont_nxt  = 1'b0;
          w_exec_nxt  = 1'b0;
          w_state_nxt = StWaitDrop;
        end
        StWaitDrop: w_state_nxt = r_step ? StWaitHalt : StIdle;
        StWaitHalt: begin
          w_step_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end else if (w_cnt_max) begin
      // Abandon the command; consRUN is deliberately left as it was.
      w_cnt_nxt     = '0;
      w_timeout_nxt = 1'b1;
      w_cont_nxt    = 1'b0;
      w_exec_nxt    = 1'b0;
      w_step_nxt    = 1'b0;
      w_state_nxt   = StIdle;
    end else begin
      w_cnt_nxt = r_cnt + CNTW'(1);
    end
  end

  // Sequencer state and command output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_run     <= 1'b0;
      r_cont    <= 1'b0;
      r_exec    <= 1'b0;
      r_step    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_run     <= w_run_nxt;
      r_cont    <= w_cont_nxt;
      r_exec    <= w_exec_nxt;
      r_step    <= w_step_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // cpuHALT edge detector, independent of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt_last  <= 1'b0;
      r_halt_evt   <= 1'b0;
      r_unhalt_evt <= 1'b0;
    end else begin
      r_halt_last  <= cpuHALT;
      r_halt_evt   <= cpuHALT & ~r_halt_last;
      r_unhalt_evt <= ~cpuHALT & r_halt_last;
    end
  end

  assign busy       = (r_state != StIdle);
  assign cmd_ready  = (r_state == StIdle);
  assign consRUN    = r_run;
  assign consCONT   = r_cont;
  assign consEXEC   = r_exec;
  assign consSTEP   = r_step;
  assign timeout    = r_timeout;
  assign halt_evt   = r_halt_evt;
  assign unhalt_evt = r_unhalt_evt;

endmodule

// File: tb/tb_cons_run_ctl.sv
// Bench for cons_run_ctl: directed test-plan sequences followed by random
// command/CPU traffic, every cycle compared against a behavioural model.
module tb_cons_run_ctl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       consRUN, consCONT, consEXEC, consSTEP;
  logic       cpuHALT, cpuRUN, cpuCONT;
  logic       busy, timeout, halt_evt, unhalt_evt;

  int n_total = 0;
  int n_bad   = 0;

  cons_run_ctl #(.TIMEOUT(TO), .CNTW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .consRUN    (consRUN),
    .consCONT   (consCONT),
    .consEXEC   (consEXEC),
    .consSTEP   (consSTEP),
    .cpuHALT    (cpuHALT),
    .cpuRUN     (cpuRUN),
    .cpuCONT    (cpuCONT),
    .busy       (busy),
    .timeout    (timeout),
    .halt_evt   (halt_evt),
    .unhalt_evt (unhalt_evt)
  );

  always #5 clk = ~clk;
  assign cpuRUN = ~cpuHALT;

  // Reference model: which handshake is pending and how long we have waited.
  localparam int PIdle = 0, PAck = 1, PDrop = 2, PHalt = 3;
  int m_phase, m_waited;
  bit m_run, m_cont, m_exec, m_step, m_to, m_hevt, m_uevt, m_last;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ex;
    if (rst) begin
      m_phase = PIdle; m_waited = 0;
      m_run = 0; m_cont = 0; m_exec = 0; m_step = 0; m_to = 0;
      m_hevt = 0; m_uevt = 0; m_last = 0;
      return;
    end
    m_hevt = cpuHALT && !m_last;
    m_uevt = !cpuHALT && m_last;
    m_last = cpuHALT;
    if (m_phase == PIdle) begin
      m_waited = 0;
      if (cmd_valid) begin
        case (cmd_code)
          3'd1: m_run = 1;
          3'd2: begin m_run = 0; m_phase = PHalt; end
          3'd3: begin m_cont = 1; m_phase = PAck; end
          3'd4: begin m_cont = 1; m_exec = 1; m_phase = PAck; end
          3'd5: begin m_cont = 1; m_step = 1; m_phase = PAck; end
          3'd6: m_to = 0;
          default: ;
        endcase
      end
    end else begin
      ex = (m_phase == PAck)  ? cpuCONT :
           (m_phase == PDrop) ? !cpuCONT : cpuHALT;
      if (ex) begin
        m_waited = 0;
        if (m_phase == PAck) begin
          m_cont = 0; m_exec = 0; m_phase = PDrop;
        end else if (m_phase == PDrop) begin
          m_phase = m_step ? PHalt : PIdle;
        end else begin
          m_step = 0; m_phase = PIdle;
        end
      end else begin
        m_waited++;
        if (m_waited >= int'(TO)) begin
          m_to = 1; m_cont = 0; m_exec = 0; m_step = 0;
          m_phase = PIdle; m_waited = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("cmd_ready", cmd_ready, m_phase == PIdle);
    chk("busy", busy, m_phase != PIdle);
    chk("consRUN", consRUN, m_run);
    chk("consCONT", consCONT, m_cont);
    chk("consEXEC", consEXEC, m_exec);
    chk("consSTEP", consSTEP, m_step);
    chk("timeout", timeout, m_to);
    chk("halt_evt", halt_evt, m_hevt);
    chk("unhalt_evt", unhalt_evt, m_uevt);
    chk("exec_in_idle", consEXEC & cmd_ready, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [2:0] code);
    cmd_valid = 1'b1;
    cmd_code  = code;
    tick();
    cmd_valid = 1'b0;
    cmd_code  = 3'd0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = 3'd0; cpuHALT = 1'b1; cpuCONT = 1'b0;
    cycles(3);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_run", consRUN, 1'b0);
    rst = 1'b0;
    tick();
    chk("first_halt_evt", halt_evt, 1'b1);
    tick();
    chk("halt_evt_one_cycle", halt_evt, 1'b0);

    // RUN then CONT with a delayed acknowledge.
    cpuHALT = 1'b0;
    tick();
    issue(3'd1);
    issue(3'd3);
    cycles(4);
    chk("cont_held", consCONT, 1'b1);
    cpuCONT = 1'b1;
    tick();
    chk("cont_dropped", consCONT, 1'b0);
    cycles(2);
    cpuCONT = 1'b0;
    tick();
    chk("cont_idle", cmd_ready, 1'b1);
    chk("cont_run_kept", consRUN, 1'b1);

    // STEP: ack, drop, then halt after a while.
    cpuHALT = 1'b1;
    tick();
    issue(3'd5);
    cycles(2);
    cpuCONT = 1'b1; cpuHALT = 1'b0;
    tick();
    cycles(2);
    cpuCONT = 1'b0;
    tick();
    chk("step_wait_halt", consSTEP, 1'b1);
    cycles(10);
    cpuHALT = 1'b1;
    tick();
    chk("step_cleared", consSTEP, 1'b0);
    chk("step_idle", busy, 1'b0);

    // CONT with no acknowledge: times out after TO wait cycles.
    issue(3'd3);
    cycles(TO - 1);
    chk("to_not_yet", timeout, 1'b0);
    tick();
    chk("to_set", timeout, 1'b1);
    chk("to_cont_cleared", consCONT, 1'b0);
    issue(3'd6);
    chk("clrerr", timeout, 1'b0);

    // HALT whose completion coincides with the last wait cycle.
    cpuHALT = 1'b0;
    tick();
    issue(3'd2);
    cycles(TO - 1);
    cpuHALT = 1'b1;
    tick();
    chk("halt_edge_no_to", timeout, 1'b0);
    chk("halt_edge_idle", busy, 1'b0);
    issue(3'd2);
    chk("halt2_busy", busy, 1'b1);
    tick();
    chk("halt2_done", busy, 1'b0);

    // EXEC interrupted by reset; commands ignored while busy.
    issue(3'd4);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_exec", consEXEC, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    tick();
    issue(3'd3);
    cmd_valid = 1'b1; cmd_code = 3'd1;
    cycles(3);
    cmd_valid = 1'b0;
    cpuCONT = 1'b1;
    tick();
    cpuCONT = 1'b0;
    tick();
    chk("ignored_run", consRUN, 1'b0);
    chk("ignored_idle", busy, 1'b0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_code  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) cpuCONT = ~cpuCONT;
      if ($urandom_range(0, 7) == 0) cpuHALT = ~cpuHALT;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cons_run_ctl.md
Name: cons_run_ctl

Overview:
Console-side run-control sequencer; the counterpart to the CPU's run/halt/continue logic. Accepts discrete console commands (RUN, HALT, CONT, EXEC, STEP) and drives the CPU's consRUN/consCONT/consEXEC/consSTEP inputs. It completes each command using the CPU's cpuCONT/cpuHALT/cpuRUN status as handshake, with timeout detection. It also reports halt/unhalt edges to the console interrupt logic.

Parameters:
TIMEOUT, 1024, cycles allowed in any wait state before abort (must be >= 2)
CNTW, 11, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command strobe; accepted when cmd_ready=1
cmd_code  in  3  0=NOP 1=RUN 2=HALT 3=CONT 4=EXEC 5=STEP 6=CLRERR 7=reserved
cmd_ready  out  1  high only in IDLE
consRUN  out  1  run enable level to CPU
consCONT  out  1  continue request to CPU
consEXEC  out  1  execute-switch request to CPU
consSTEP  out  1  single-step request to CPU
cpuHALT  in  1  CPU halted status
cpuRUN  in  1  CPU run status
cpuCONT  in  1  CPU continue acknowledge
busy  out  1  not IDLE
timeout  out  1  sticky timeout flag
halt_evt  out  1  one-cycle pulse, cpuHALT 0->1
unhalt_evt  out  1  one-cycle pulse, cpuHALT 1->0

Behaviour:
- Clock: one clock (clk); reset synchronous, active-high (rst). All outputs registered.
- Reset values: consRUN=0, consCONT=0, consEXEC=0, consSTEP=0, timeout=0, halt_evt=0, unhalt_evt=0, busy=0, cmd_ready=1. The halt-history register is reset to 0, so cpuHALT=1 on the first cycle after reset yields halt_evt.
- States: IDLE, WAIT_ACK, WAIT_DROP, WAIT_HALT.
- Acceptance: cmd_valid & cmd_ready in IDLE. The next cycle reflects the command. cmd_valid is ignored outside IDLE; there is no queueing.
- NOP, reserved(7): accepted, no effect, stay IDLE.
- RUN: consRUN<=1, stay IDLE. Single-cycle command.
- CLRERR: timeout<=0, stay IDLE.
- HALT: consRUN<=0 -> WAIT_HALT.
- CONT: consCONT<=1 -> WAIT_ACK.
- EXEC: consCONT<=1, consEXEC<=1 -> WAIT_ACK.
- STEP: consCONT<=1, consSTEP<=1 -> WAIT_ACK.
- WAIT_ACK: on sampled cpuCONT=1, consCONT<=0 and consEXEC<=0 -> WAIT_DROP.
- WAIT_DROP: on cpuCONT=0, go to WAIT_HALT if consSTEP=1, else IDLE.
- WAIT_HALT: on cpuHALT=1, consSTEP<=0 -> IDLE.
  - HALT issued while already halted completes in 1 wait cycle.
  - cpuRUN is not a handshake term; it only qualifies nothing.
- Timeout counter:
  - Cleared on every state entry; increments each cycle in any wait state.
  - On count==TIMEOUT-1 with the exit condition false: timeout<=1; consCONT, consEXEC, consSTEP <=0; consRUN unchanged; -> IDLE.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins and timeout is not set.
- Edge detect: halt_evt = cpuHALT & ~last; unhalt_evt = ~cpuHALT & last. Both registered, and independent of the state machine.
- Reset mid-operation: immediate return to IDLE with all reset values. No completion signalled.
- busy = (state != IDLE); cmd_ready = ~busy.
- Invariant: consEXEC=1 or consSTEP=1 implies a command is in progress. consEXEC is never high in IDLE.

Test Plan:
- Reset, cpuHALT=1 held -> one halt_evt pulse 1 cycle after reset release; all cons* = 0; cmd_ready=1.
- RUN then CONT; CPU asserts cpuCONT 5 cycles after consCONT, drops it 3 cycles later -> consCONT high exactly until the cycle after cpuCONT is sampled high; IDLE 1 cycle after cpuCONT=0; consRUN stays 1; timeout=0.
- STEP with cpuCONT ack/drop, then cpuHALT 0->1 after 20 cycles -> consSTEP clears on halt; unhalt_evt then halt_evt pulses seen; final state IDLE.
- CONT with cpuCONT never asserted, TIMEOUT=16 -> timeout=1 after exactly 16 wait cycles; consCONT=0; cmd_ready=1. CLRERR -> timeout=0.
- HALT with cpuHALT rising on exactly cycle TIMEOUT-1 -> completes normally, timeout stays 0. A second HALT while halted -> back to IDLE in 1 cycle.
- EXEC, then rst asserted during WAIT_ACK -> next cycle all outputs at reset values. cmd_valid pulses during busy are ignored (no state change after return to IDLE).
